// File: rtl/half_sine_chip_demod.sv
// Half-sine chip demodulator: zero-crossing acquisition, per-chip integrate-and-dump, lock tracking.
// Optional macro DEMOD_CHIP_STATS_EN adds chip_count / miss_count statistics outputs.
module half_sine_chip_demod #(
  parameter int SAMPLES_PER_CHIP = 8,
  parameter int MIDSCALE         = 8,
  parameter int CHIP_THRESHOLD   = 16,
  parameter int LOCK_COUNT       = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [3:0]  sample_in,
  input  logic        sample_valid,
  output logic        chip_out,
  output logic        chip_valid,
  output logic        locked
`ifdef DEMOD_CHIP_STATS_EN
  ,
  output logic [15:0] chip_count,
  output logic [15:0] miss_count
`endif
);

  localparam int LOG_SPC = $clog2(SAMPLES_PER_CHIP);
  localparam int ACC_W   = 5 + LOG_SPC;
  localparam int CNT_W   = LOG_SPC + 1;
  localparam int GOOD_W  = $clog2(LOCK_COUNT + 1);

  localparam logic signed [4:0]   MID_C = 5'(MIDSCALE);
  localparam logic [CNT_W-1:0]    SPC_C = CNT_W'(SAMPLES_PER_CHIP);
  localparam logic [ACC_W-1:0]    THR_C = ACC_W'(CHIP_THRESHOLD);
  localparam logic [GOOD_W-1:0]   LOCK_C = GOOD_W'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, SEARCH, INTEGRATE} state_t;

  state_t                    state;
  logic signed [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]          count;
  logic signed [4:0]         prev_c;
  logic [GOOD_W-1:0]         good_cnt;
  logic                      miss_pend;

  logic signed [4:0]         c;
  logic signed [ACC_W-1:0]   c_ext;
  logic signed [ACC_W-1:0]   acc_next;
  logic [CNT_W-1:0]          count_next;
  logic                      crossing;
  logic                      period_close;
  logic                      good_chip;
  logic [GOOD_W-1:0]         good_inc;

  function automatic logic [ACC_W-1:0] magnitude(input logic signed [ACC_W-1:0] v);
    magnitude = v[ACC_W-1] ? ACC_W'(-v) : ACC_W'(v);
  endfunction

  function automatic logic [GOOD_W-1:0] sat_inc_good(input logic [GOOD_W-1:0] v);
    sat_inc_good = (v >= LOCK_C) ? LOCK_C : v + GOOD_W'(1);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign c     = signed'({1'b0, sample_in}) - MID_C;
  assign c_ext = ACC_W'(c);

  // A full count means the previous period already closed, so this sample opens a new one.
  assign acc_next     = (count == SPC_C) ? c_ext : acc + c_ext;
  assign count_next   = (count == SPC_C) ? CNT_W'(1) : count + CNT_W'(1);
  assign period_close = (count_next == SPC_C);
  assign good_chip    = (magnitude(acc_next) >= THR_C);
  assign good_inc     = sat_inc_good(good_cnt);

  assign crossing = ((prev_c <= 5'sd0) && (c > 5'sd0)) ||
                    ((prev_c >= 5'sd0) && (c < 5'sd0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      acc        <= '0;
      count      <= '0;
      prev_c     <= '0;
      good_cnt   <= '0;
      miss_pend  <= 1'b0;
      chip_out   <= 1'b0;
      chip_valid <= 1'b0;
      locked     <= 1'b0;
`ifdef DEMOD_CHIP_STATS_EN
      chip_count <= '0;
      miss_count <= '0;
`endif
    end else begin
      chip_valid <= 1'b0;
      if (!enable) begin
        state     <= IDLE;
        acc       <= '0;
        count     <= '0;
        good_cnt  <= '0;
        miss_pend <= 1'b0;
        locked    <= 1'b0;
`ifdef DEMOD_CHIP_STATS_EN
        chip_count <= '0;
        miss_count <= '0;
`endif
      end else begin
        case (state)
          IDLE: state <= SEARCH;
          SEARCH: begin
            if (sample_valid) begin
              prev_c <= c;
              if (crossing) begin
                acc   <= c_ext;
                count <= CNT_W'(1);
                state <= INTEGRATE;
              end
            end
          end
          INTEGRATE: begin
            if (sample_valid) begin
              prev_c <= c;
              acc    <= acc_next;
              count  <= count_next;
              if (period_close) begin
                if (good_chip) begin
                  chip_valid <= 1'b1;
                  chip_out   <= ~acc_next[ACC_W-1];
                  good_cnt   <= good_inc;
                  miss_pend  <= 1'b0;
                  if (good_inc == LOCK_C) locked <= 1'b1;
`ifdef DEMOD_CHIP_STATS_EN
                  chip_count <= chip_count + 16'd1;
`endif
                end else begin
                  good_cnt <= '0;
`ifdef DEMOD_CHIP_STATS_EN
                  miss_count <= sat_inc16(miss_count);
`endif
                  // Second consecutive miss: timing is lost, reacquire from a fresh crossing.
                  if (miss_pend) begin
                    miss_pend <= 1'b0;
                    locked    <= 1'b0;
                    acc       <= '0;
                    count     <= '0;
                    state     <= SEARCH;
                  end else begin
                    miss_pend <= 1'b1;
                  end
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_half_sine_chip_demod.sv
// Self-checking bench for half_sine_chip_demod against a sample-window reference model.
// Define DEMOD_CHIP_STATS_EN for both files to also check the statistics outputs.
module tb_half_sine_chip_demod;

  localparam int SPC  = 8;
  localparam int MID  = 8;
  localparam int THR  = 16;
  localparam int LOCK = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  sample_in = 4'd8;
  logic        sample_valid = 1'b0;
  logic        chip_out, chip_valid, locked;
`ifdef DEMOD_CHIP_STATS_EN
  logic [15:0] chip_count, miss_count;
`endif

  half_sine_chip_demod #(
    .SAMPLES_PER_CHIP(SPC), .MIDSCALE(MID), .CHIP_THRESHOLD(THR), .LOCK_COUNT(LOCK)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .sample_in(sample_in),
    .sample_valid(sample_valid), .chip_out(chip_out), .chip_valid(chip_valid), .locked(locked)
`ifdef DEMOD_CHIP_STATS_EN
    , .chip_count(chip_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // pulse kinds: 0 positive, 1 negative, 2 weak positive, 3 flat
  logic [3:0] pulse_tab [4][8] = '{
    '{4'd8, 4'd11, 4'd13, 4'd15, 4'd15, 4'd13, 4'd11, 4'd8},
    '{4'd8, 4'd5,  4'd3,  4'd1,  4'd1,  4'd3,  4'd5,  4'd8},
    '{4'd8, 4'd9,  4'd9,  4'd9,  4'd9,  4'd9,  4'd9,  4'd8},
    '{4'd8, 4'd8,  4'd8,  4'd8,  4'd8,  4'd8,  4'd8,  4'd8}
  };

  // Reference model: 0 idle, 1 hunting for a crossing, 2 collecting a chip window.
  int  m_mode = 0;
  int  m_prev = 0;
  int  m_win[$];
  int  m_good = 0;
  int  m_miss = 0;
  bit  m_cv = 0, m_co = 0, m_lk = 0;
  int  m_cc = 0, m_mc = 0;

  logic [34:0] obs_q[$];
  logic [34:0] exp_q[$];
  bit          strobe_q[$];
  bit          lk_q[$];

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_win.delete(); m_good = 0; m_miss = 0;
    m_cv = 0; m_co = 0; m_lk = 0; m_cc = 0; m_mc = 0;
  endtask

  task automatic model_step(input bit en, input bit vld, input int s);
    int c, sum;
    m_cv = 0;
    if (!en) begin
      m_mode = 0; m_win.delete(); m_good = 0; m_miss = 0; m_lk = 0; m_cc = 0; m_mc = 0;
      return;
    end
    c = s - MID;
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (vld) begin
        if ((m_prev <= 0 && c > 0) || (m_prev >= 0 && c < 0)) begin
          m_win = {c};
          m_mode = 2;
        end
        m_prev = c;
      end
    end else if (vld) begin
      m_prev = c;
      m_win.push_back(c);
      if (m_win.size() == SPC) begin
        sum = m_win.sum();
        m_win.delete();
        if (sum >= THR || -sum >= THR) begin
          m_cv = 1; m_co = (sum > 0);
          m_good = (m_good + 1 > LOCK) ? LOCK : m_good + 1;
          m_miss = 0;
          m_cc = (m_cc + 1) % 65536;
          if (m_good >= LOCK) m_lk = 1;
        end else begin
          m_good = 0;
          m_mc = (m_mc < 65535) ? m_mc + 1 : 65535;
          m_miss++;
          if (m_miss >= 2) begin
            m_miss = 0; m_lk = 0; m_mode = 1;
          end
        end
      end
    end
  endtask

  task automatic step(input bit en, input bit vld, input logic [3:0] s);
    logic [34:0] o, e;
    enable = en; sample_valid = vld; sample_in = s;
    model_step(en, vld, int'(s));
    @(posedge clk); #1;
    o = {chip_valid, chip_out, locked, 32'd0};
    e = {m_cv, m_co, m_lk, 32'd0};
`ifdef DEMOD_CHIP_STATS_EN
    o[31:0] = {chip_count, miss_count};
    e[31:0] = {16'(m_cc), 16'(m_mc)};
`endif
    obs_q.push_back(o);
    exp_q.push_back(e);
    if (chip_valid === 1'b1) begin
      strobe_q.push_back(chip_out);
      lk_q.push_back(locked);
    end
  endtask

  task automatic feed_pulse(input int kind, input int gap);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, pulse_tab[kind][i]);
      if (gap > 0 && (i % 3) == 2)
        for (int g = 0; g < gap; g++) step(1'b1, 1'b0, 4'($urandom_range(0, 15)));
    end
  endtask

  task automatic restart();
    step(1'b0, 1'b0, 4'd8);
    step(1'b1, 1'b0, 4'd8);
  endtask

  task automatic clear_q();
    obs_q.delete(); exp_q.delete(); strobe_q.delete(); lk_q.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; sample_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_assert++;
    if ({chip_valid, chip_out, locked} !== 3'b000) begin
      n_fail++; $display("FAIL reset_outputs: got %b want 000", {chip_valid, chip_out, locked});
    end
`ifdef DEMOD_CHIP_STATS_EN
    n_assert++;
    if ({chip_count, miss_count} !== 32'd0) begin
      n_fail++; $display("FAIL reset_stats: got %h want 0", {chip_count, miss_count});
    end
`endif
    #3 reset_n = 1'b1;
  endtask

  task automatic test_lock();
    restart(); clear_q();
    for (int p = 0; p < 6; p++) feed_pulse(0, 0);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_assert++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL lock_cycle%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_assert++;
    if (strobe_q.size() != 5) begin
      n_fail++; $display("FAIL lock_strobes: got %0d want 5", strobe_q.size());
    end
    foreach (strobe_q[i]) begin
      n_assert++;
      if (strobe_q[i] !== 1'b1) begin
        n_fail++; $display("FAIL lock_chip%0d: got %b want 1", i, strobe_q[i]);
      end
    end
    n_assert++;
    if (lk_q.size() < 4 || lk_q[2] !== 1'b0 || lk_q[3] !== 1'b1) begin
      n_fail++; $display("FAIL lock_rise: got %p want locked on 4th strobe", lk_q);
    end
  endtask

  task automatic test_alternate();
    bit want [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    clear_q();
    for (int p = 0; p < 4; p++) feed_pulse(p % 2 == 0 ? 1 : 0, 0);
    step(1'b1, 1'b1, 4'd8);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_assert++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL alt_cycle%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_assert++;
    if (strobe_q.size() != 5) begin
      n_fail++; $display("FAIL alt_strobes: got %0d want 5", strobe_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_assert++;
        if (strobe_q[i] !== want[i] || lk_q[i] !== 1'b1) begin
          n_fail++; $display("FAIL alt_chip%0d: got chip %b lock %b want chip %b lock 1",
                             i, strobe_q[i], lk_q[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_loss_relock();
    clear_q();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 4'd8);
    n_assert++;
    if (strobe_q.size() != 0 || locked !== 1'b0) begin
      n_fail++; $display("FAIL loss: got strobes %0d locked %b want 0 0", strobe_q.size(), locked);
    end
    for (int p = 0; p < 5; p++) feed_pulse(0, 0);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_assert++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL loss_cycle%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_assert++;
    if (lk_q.size() < 4 || lk_q[2] !== 1'b0 || lk_q[3] !== 1'b1) begin
      n_fail++; $display("FAIL relock: got %p want locked on 4th strobe", lk_q);
    end
  endtask

  task automatic test_weak();
    restart(); clear_q();
    for (int p = 0; p < 4; p++) feed_pulse(2, 0);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_assert++;
      if (obs_q[i] !== exp_q[i] || obs_q[i][34] !== 1'b0 || obs_q[i][32] !== 1'b0) begin
        n_fail++; $display("FAIL weak_cycle%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_async();
    restart(); clear_q();
    for (int p = 0; p < 6; p++) feed_pulse(0, 0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, pulse_tab[0][i]);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    n_assert++;
    if ({chip_valid, chip_out, locked} !== 3'b000) begin
      n_fail++; $display("FAIL async_reset: got %b want 000", {chip_valid, chip_out, locked});
    end
    @(posedge clk); @(posedge clk);
    #4 reset_n = 1'b1;
    for (int i = 3; i < 8; i++) step(1'b1, 1'b1, pulse_tab[0][i]);
    for (int p = 0; p < 6; p++) feed_pulse(0, 0);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_assert++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL areset_cycle%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_gaps();
    restart(); clear_q();
    for (int p = 0; p < 6; p++) feed_pulse(0, 3);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_assert++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL gap_cycle%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_assert++;
    if (strobe_q.size() != 5 || strobe_q.sum() with (int'(item)) != 5) begin
      n_fail++; $display("FAIL gap_strobes: got %p want five 1s", strobe_q);
    end
    n_assert++;
    if (lk_q.size() < 4 || lk_q[2] !== 1'b0 || lk_q[3] !== 1'b1) begin
      n_fail++; $display("FAIL gap_lock: got %p want locked on 4th strobe", lk_q);
    end
  endtask

  task automatic test_disable_on_close();
    restart(); clear_q();
    feed_pulse(0, 0);
    step(1'b0, 1'b1, 4'd8);
    n_assert++;
    if (chip_valid !== 1'b0 || strobe_q.size() != 0) begin
      n_fail++; $display("FAIL disable_close: got chip_valid %b want 0", chip_valid);
    end
    step(1'b1, 1'b0, 4'd8);
    for (int p = 0; p < 2; p++) feed_pulse(0, 0);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_assert++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL dis_cycle%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    restart(); clear_q();
    for (int p = 0; p < 60; p++) begin
      if ($urandom_range(0, 14) == 0) step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      feed_pulse($urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end
    for (int i = 0; i < obs_q.size(); i++) begin
      n_assert++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rand_cycle%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

`ifdef DEMOD_CHIP_STATS_EN
  task automatic test_stats();
    restart(); clear_q();
    for (int p = 0; p < 6; p++) feed_pulse(0, 0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 4'd8);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_assert++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL stats_cycle%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    step(1'b0, 1'b0, 4'd8);
    n_assert++;
    if ({chip_count, miss_count} !== 32'd0) begin
      n_fail++; $display("FAIL stats_clear: got %h want 0", {chip_count, miss_count});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lock();
    test_alternate();
    test_loss_relock();
    test_weak();
    test_reset_async();
    test_gaps();
    test_disable_on_close();
    test_random();
`ifdef DEMOD_CHIP_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
